// File: rtl/mm_bank_loader.sv
// Word-serial A-then-B loader that splits both matrices into the dual-bank memories used by mm_parallel.
// Optional stream framing check: define MM_LOADER_TLAST_CHECK_EN.
module mm_bank_loader #(
  parameter int width        = 8,
  parameter int A_depth_bits = 9,
  parameter int B_depth_bits = 9,
  parameter int M            = 64,
  parameter int N            = 8,
  parameter int P            = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ctrl_start,
  output logic                    ctrl_busy,
  output logic                    ctrl_done,
  output logic                    ctrl_err,
  input  logic [width-1:0]        s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  output logic [A_depth_bits-1:0] A_write_address,
  output logic [width-1:0]        A_write_data_in,
  output logic                    A0_write_en,
  output logic                    A1_write_en,
  output logic [B_depth_bits-1:0] B_write_address,
  output logic [width-1:0]        B_write_data_in,
  output logic                    B0_write_en,
  output logic                    B1_write_en,
  output logic                    mm_start,
  input  logic                    mm_done
);
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int RW   = (M > 1) ? $clog2(M) : 1;
  localparam int PW   = (P > 1) ? $clog2(P) : 1;
  localparam int HALF = N / 2;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, RUN, FINISH} state_t;

  state_t                  state_reg;
  logic [CW-1:0]           a_col_reg;
  logic [RW-1:0]           a_row_reg;
  logic [A_depth_bits-1:0] a0_ptr_reg;
  logic [A_depth_bits-1:0] a1_ptr_reg;
  logic [CW-1:0]           b_row_reg;
  logic [PW-1:0]           b_col_reg;
  logic [B_depth_bits-1:0] b_ptr_reg;
  logic                    err_reg;

  logic accept, a_lo, a_last, b_lo, b_row_end, b_last;
  logic tlast_bad, tlast_missing;

  assign s_tready  = (state_reg == LOAD_A) || (state_reg == LOAD_B);
  assign ctrl_busy = (state_reg != IDLE);
  assign accept    = s_tvalid & s_tready;

  // Each bank sees its elements in stream order, so a plain per-bank pointer yields the address.
  assign a_lo      = a_col_reg < CW'(HALF);
  assign a_last    = (a_row_reg == RW'(M - 1)) && (a_col_reg == CW'(N - 1));
  assign b_lo      = b_row_reg < CW'(HALF);
  assign b_row_end = (b_col_reg == PW'(P - 1));
  assign b_last    = (b_row_reg == CW'(N - 1)) && b_row_end;

`ifdef MM_LOADER_TLAST_CHECK_EN
  assign tlast_bad     = s_tlast & ~((state_reg == LOAD_B) && b_last);
  assign tlast_missing = ~s_tlast & b_last;
  assign ctrl_err      = err_reg;
`else
  logic unused_tlast;
  assign unused_tlast  = s_tlast | err_reg;
  assign tlast_bad     = 1'b0;
  assign tlast_missing = 1'b0;
  assign ctrl_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= IDLE;
      a_col_reg       <= '0;
      a_row_reg       <= '0;
      a0_ptr_reg      <= '0;
      a1_ptr_reg      <= '0;
      b_row_reg       <= '0;
      b_col_reg       <= '0;
      b_ptr_reg       <= '0;
      err_reg         <= 1'b0;
      A_write_address <= '0;
      A_write_data_in <= '0;
      A0_write_en     <= 1'b0;
      A1_write_en     <= 1'b0;
      B_write_address <= '0;
      B_write_data_in <= '0;
      B0_write_en     <= 1'b0;
      B1_write_en     <= 1'b0;
      mm_start        <= 1'b0;
      ctrl_done       <= 1'b0;
    end else begin
      A0_write_en <= 1'b0;
      A1_write_en <= 1'b0;
      B0_write_en <= 1'b0;
      B1_write_en <= 1'b0;
      ctrl_done   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ctrl_start) begin
            state_reg  <= LOAD_A;
            a_col_reg  <= '0;
            a_row_reg  <= '0;
            a0_ptr_reg <= '0;
            a1_ptr_reg <= '0;
            b_row_reg  <= '0;
            b_col_reg  <= '0;
            b_ptr_reg  <= '0;
            err_reg    <= 1'b0;
          end
        end
        LOAD_A: begin
          if (accept) begin
            if (tlast_bad) begin
              err_reg   <= 1'b1;
              state_reg <= IDLE;
            end else begin
              A_write_data_in <= s_tdata;
              A_write_address <= a_lo ? a0_ptr_reg : a1_ptr_reg;
              A0_write_en     <= a_lo;
              A1_write_en     <= ~a_lo;
              if (a_lo) a0_ptr_reg <= a0_ptr_reg + 1'b1;
              else      a1_ptr_reg <= a1_ptr_reg + 1'b1;
              if (a_col_reg == CW'(N - 1)) begin
                a_col_reg <= '0;
                a_row_reg <= a_row_reg + 1'b1;
              end else begin
                a_col_reg <= a_col_reg + 1'b1;
              end
              if (a_last) state_reg <= LOAD_B;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            if (tlast_bad) begin
              err_reg   <= 1'b1;
              state_reg <= IDLE;
            end else begin
              B_write_data_in <= s_tdata;
              B_write_address <= b_ptr_reg;
              B0_write_en     <= b_lo;
              B1_write_en     <= ~b_lo;
              // B1 addressing restarts once the lower half of the rows is done
              if ((b_row_reg == CW'(HALF - 1)) && b_row_end) b_ptr_reg <= '0;
              else                                           b_ptr_reg <= b_ptr_reg + 1'b1;
              if (b_row_end) begin
                b_col_reg <= '0;
                b_row_reg <= b_row_reg + 1'b1;
              end else begin
                b_col_reg <= b_col_reg + 1'b1;
              end
              if (b_last) begin
                state_reg <= RUN;
                if (tlast_missing) err_reg <= 1'b1;
              end
            end
          end
        end
        RUN: begin
          if (mm_start && mm_done) begin
            mm_start  <= 1'b0;
            ctrl_done <= 1'b1;
            state_reg <= FINISH;
          end else begin
            mm_start <= 1'b1;
          end
        end
        FINISH:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mm_bank_loader.sv
// Directed bench for mm_bank_loader with M=2, N=4, P=2; bank writes are logged and compared to a hand-built table.
module tb_mm_bank_loader;
  localparam int W  = 8;
  localparam int AD = 9;
  localparam int BD = 9;
  localparam int M  = 2;
  localparam int N  = 4;
  localparam int P  = 2;
  localparam int NW = M * N + N * P;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          ctrl_start = 1'b0;
  logic          ctrl_busy, ctrl_done, ctrl_err;
  logic [W-1:0]  s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [AD-1:0] A_write_address;
  logic [W-1:0]  A_write_data_in;
  logic          A0_write_en, A1_write_en;
  logic [BD-1:0] B_write_address;
  logic [W-1:0]  B_write_data_in;
  logic          B0_write_en, B1_write_en;
  logic          mm_start;
  logic          mm_done = 1'b0;

  always #5 clk = ~clk;

  mm_bank_loader #(
    .width(W), .A_depth_bits(AD), .B_depth_bits(BD), .M(M), .N(N), .P(P)
  ) dut (
    .clk(clk), .resetn(resetn), .ctrl_start(ctrl_start), .ctrl_busy(ctrl_busy),
    .ctrl_done(ctrl_done), .ctrl_err(ctrl_err), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .s_tlast(s_tlast), .A_write_address(A_write_address),
    .A_write_data_in(A_write_data_in), .A0_write_en(A0_write_en), .A1_write_en(A1_write_en),
    .B_write_address(B_write_address), .B_write_data_in(B_write_data_in),
    .B0_write_en(B0_write_en), .B1_write_en(B1_write_en), .mm_start(mm_start), .mm_done(mm_done)
  );

  typedef struct {
    int bank;
    int addr;
    int data;
  } wr_t;

  wr_t tab[NW];
  wr_t log_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  done_cnt = 0;
  int  mon_en_cnt;

  function automatic int pack(input wr_t w);
    return w.bank * 65536 + w.addr * 256 + w.data;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Write monitor: one enable at most per cycle, every write logged in order
  always @(negedge clk) begin
    if (resetn) begin
      mon_en_cnt = int'(A0_write_en) + int'(A1_write_en) + int'(B0_write_en) + int'(B1_write_en);
      if (ctrl_done) done_cnt++;
      if (mon_en_cnt != 0) begin
        check("onehot_en", mon_en_cnt, 1);
        if (A0_write_en) log_q.push_back('{bank: 0, addr: int'(A_write_address), data: int'(A_write_data_in)});
        if (A1_write_en) log_q.push_back('{bank: 1, addr: int'(A_write_address), data: int'(A_write_data_in)});
        if (B0_write_en) log_q.push_back('{bank: 2, addr: int'(B_write_address), data: int'(B_write_data_in)});
        if (B1_write_en) log_q.push_back('{bank: 3, addr: int'(B_write_address), data: int'(B_write_data_in)});
      end
    end
  end

  function automatic int outs_or();
    return int'(|{ctrl_busy, ctrl_done, ctrl_err, s_tready, A_write_address, A_write_data_in,
                  A0_write_en, A1_write_en, B_write_address, B_write_data_in,
                  B0_write_en, B1_write_en, mm_start});
  endfunction

  task automatic send(input int d, input logic last, input int gap, input logic start_pulse);
    int guard;
    for (int g = 0; g < gap; g++) begin
      s_tvalid = 1'b0;
      @(negedge clk);
    end
    s_tdata    = W'(d);
    s_tvalid   = 1'b1;
    s_tlast    = last;
    ctrl_start = start_pulse;
    guard = 0;
    while (!s_tready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!s_tready) check("tready_timeout", 0, 1);
    @(negedge clk);
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    ctrl_start = 1'b0;
  endtask

  task automatic start_job;
    log_q.delete();
    done_cnt   = 0;
    ctrl_start = 1'b1;
    @(negedge clk);
    ctrl_start = 1'b0;
    check("busy_after_start", int'(ctrl_busy), 1);
    check("err_cleared", int'(ctrl_err), 0);
  endtask

  task automatic stream(input int gap_max, input int start_at, input logic last_ok);
    for (int k = 0; k < NW; k++)
      send(k + 1, (k == NW - 1) && last_ok, int'($urandom_range(gap_max, 0)), k == start_at);
  endtask

  task automatic finish_job(input logic pulse_run, input int exp_err);
    check("mm_start_lag", int'(mm_start), 0);
    @(negedge clk);
    check("mm_start_rise", int'(mm_start), 1);
    for (int c = 0; c < 5; c++) begin
      ctrl_start = pulse_run && (c == 2);
      @(negedge clk);
    end
    ctrl_start = 1'b0;
    check("mm_start_hold", int'(mm_start), 1);
    mm_done = 1'b1;
    @(negedge clk);
    mm_done = 1'b0;
    check("mm_start_fall", int'(mm_start), 0);
    check("done_pulse", int'(ctrl_done), 1);
    check("err_at_done", int'(ctrl_err), exp_err);
    @(negedge clk);
    check("done_low", int'(ctrl_done), 0);
    check("busy_idle", int'(ctrl_busy), 0);
    repeat (3) @(negedge clk);
    check("done_count", done_cnt, 1);
    check("busy_stays_idle", int'(ctrl_busy), 0);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_write_count"}, log_q.size(), NW);
    for (int v = 0; v < NW && v < log_q.size(); v++) begin
      $display("%s vec %0d: bank %0d addr %0d data %0d", tag, v, log_q[v].bank, log_q[v].addr, log_q[v].data);
      check({tag, "_write"}, pack(log_q[v]), pack(tab[v]));
    end
  endtask

  initial begin
    int a_bank[8];
    int a_addr[8];
    a_bank = '{0, 0, 1, 1, 0, 0, 1, 1};
    a_addr = '{0, 1, 0, 1, 2, 3, 2, 3};
    for (int k = 0; k < 8; k++) tab[k] = '{bank: a_bank[k], addr: a_addr[k], data: k + 1};
    for (int k = 8; k < 16; k++) tab[k] = '{bank: (k < 12) ? 2 : 3, addr: (k - 8) % 4, data: k + 1};

    repeat (3) @(negedge clk);
    check("reset_outputs", outs_or(), 0);
    check("reset_busy", int'(ctrl_busy), 0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_tready", int'(s_tready), 0);

    start_job();
    stream(0, -1, 1'b1);
    finish_job(1'b0, 0);
    check_writes("happy");

    start_job();
    stream(2, -1, 1'b1);
    finish_job(1'b0, 0);
    check_writes("gaps");

    start_job();
    stream(0, 10, 1'b1);
    finish_job(1'b1, 0);
    check_writes("ign_start");

    start_job();
    for (int k = 0; k < 5; k++) send(k + 1, 1'b0, 0, 1'b0);
    check("pre_reset_write", int'(A0_write_en), 1);
    resetn = 1'b0;
    #1;
    check("mid_reset_outputs", outs_or(), 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    start_job();
    stream(1, -1, 1'b1);
    finish_job(1'b0, 0);
    check_writes("after_reset");

`ifdef MM_LOADER_TLAST_CHECK_EN
    start_job();
    send(1, 1'b0, 0, 1'b0);
    send(2, 1'b0, 0, 1'b0);
    send(3, 1'b1, 0, 1'b0);
    check("tlast_err", int'(ctrl_err), 1);
    check("tlast_idle", int'(ctrl_busy), 0);
    check("tlast_no_write", int'(A1_write_en | A0_write_en), 0);
    repeat (4) @(negedge clk);
    check("tlast_no_start", int'(mm_start), 0);
    check("tlast_no_done", done_cnt, 0);
    check("tlast_write_count", log_q.size(), 2);

    start_job();
    stream(0, -1, 1'b0);
    finish_job(1'b0, 1);
    check_writes("no_tlast");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mm_bank_loader.md
# mm_bank_loader

Input-side stage for `mm_parallel`. It accepts the A matrix and then the B matrix as one word-serial stream and splits them into the four dual-bank memories that `mm_parallel` reads: A columns split into A0/A1, B rows split into B0/B1. Once loading completes, it holds `mm_parallel`'s Start until Done, then reports completion and returns to idle.

## Interface

Parameters:

- width, 8, bits per matrix element and per stream word
- A_depth_bits, 9, A0/A1 address width; M*N/2 must be ≤ 2^A_depth_bits
- B_depth_bits, 9, B0/B1 address width; N*P/2 must be ≤ 2^B_depth_bits
- M, 64, rows of A
- N, 8, inner dimension; must be even
- P, 2, columns of B

Ports:

- clk  in  1  single clock; all state changes on the rising edge
- resetn  in  1  asynchronous, active-low reset
- ctrl_start  in  1  one-cycle request; starts a load+compute job
- ctrl_busy  out  1  high whenever state ≠ IDLE
- ctrl_done  out  1  one-cycle pulse when the job has finished
- ctrl_err  out  1  sticky stream-framing error (see Configuration)
- s_tdata  in  width  stream word
- s_tvalid  in  1  stream word valid
- s_tready  out  1  loader can accept a word
- s_tlast  in  1  marks the final B word
- A_write_address  out  A_depth_bits  shared address for A0/A1
- A_write_data_in  out  width  shared data for A0/A1
- A0_write_en  out  1  write strobe, A columns 0..N/2-1
- A1_write_en  out  1  write strobe, A columns N/2..N-1
- B_write_address  out  B_depth_bits  shared address for B0/B1
- B_write_data_in  out  width  shared data for B0/B1
- B0_write_en  out  1  write strobe, B rows 0..N/2-1
- B1_write_en  out  1  write strobe, B rows N/2..N-1
- mm_start  out  1  drives `mm_parallel` Start
- mm_done  in  1  from `mm_parallel` Done

## Operation

- States: IDLE, LOAD_A, LOAD_B, RUN, FINISH.
- IDLE → LOAD_A when ctrl_start=1. This clears the row/column counters and ctrl_err. ctrl_start is ignored in every other state.
- A stream order is row-major, M*N words. Element (i,c):
  - c < N/2: A0 at address i*(N/2)+c
  - otherwise: A1 at address i*(N/2)+(c−N/2)
- LOAD_A → LOAD_B on acceptance of word M*N−1.
- B stream order is row-major, N*P words. Element (r,k):
  - r < N/2: B0 at address r*P+k
  - otherwise: B1 at address (r−N/2)*P+k
- LOAD_B → RUN on acceptance of word N*P−1.
- Addresses come from incrementing counters (column/row wrap), not multipliers.
- RUN: mm_start is held 1 until mm_done is sampled 1. Then mm_start goes to 0 and the state moves to FINISH. mm_done is ignored outside RUN.
- FINISH: ctrl_done=1 for one cycle, then IDLE.
- Data passes through unmodified; no width conversion.

## Timing

- s_tready = 1 exactly in LOAD_A and LOAD_B. A word is accepted on an edge with s_tvalid & s_tready. Throughput is one word per cycle, and s_tvalid gaps are allowed.
- Writes are registered. A word accepted at edge E drives its write_en, address and data during the cycle after E, so the RAM captures it at edge E+1. write_en is low in every cycle without a fresh acceptance, and exactly one of the four enables is high per write.
- mm_start rises at edge E+1 after the final B word is accepted at edge E, i.e. after that last write is committed.
- mm_start falls on the edge that samples mm_done=1. ctrl_done pulses in the following cycle.
- Reset values:
  - state IDLE
  - all write_en, mm_start, ctrl_busy, ctrl_done, ctrl_err, s_tready = 0
  - addresses and data = 0
- Reset asserted mid-job aborts immediately. Bank contents are then undefined, and mm_start drops asynchronously.

## Configuration

- MM_LOADER_TLAST_CHECK_EN defined:
  - s_tlast=1 on any accepted word other than the final B word sets ctrl_err, drops all strobes and returns to IDLE without pulsing mm_start or ctrl_done.
  - s_tlast=0 on the final B word sets ctrl_err but the job continues normally.
- Not defined: s_tlast is ignored and ctrl_err is tied to 0.

## Test plan

Params M=2, N=4, P=2 unless stated.

- Reset values: resetn low for 3 cycles → every output 0; ctrl_busy=0.
- Happy path: ctrl_start, stream A = 1..8 then B = 9..16 with tvalid held high.
  - A0 writes (addr:data) 0:1, 1:2, 2:5, 3:6; A1 writes 0:3, 1:4, 2:7, 3:8.
  - B0 writes 0:9, 1:10, 2:11, 3:12; B1 writes 0:13, 1:14, 2:15, 3:16.
  - mm_start rises one cycle after the 16th accept.
  - mm_done driven high 5 cycles later → mm_start falls next edge, ctrl_done pulses once.
- Backpressure/gaps: tvalid toggled randomly → identical writes to the happy path; no write_en in gap cycles.
- Ignored start: ctrl_start pulsed during LOAD_B and RUN → no effect; one ctrl_done total.
- Mid-load reset: resetn low after 5 accepts → all outputs 0 in the same cycle. A new job afterwards completes correctly.
- MM_LOADER_TLAST_CHECK_EN: tlast on word 3 → ctrl_err=1, back to IDLE, mm_start never rises. Missing tlast on word 16 → ctrl_err=1 and ctrl_done still pulses.
